// File: rtl/inst_rom_resp_pkg.sv
// Shared definitions for the instruction ROM responder: bus widths, FSM states,
// the NOP word returned on bad fetches, and the fetch address legality check.
package inst_rom_resp_pkg;

    localparam int RegBus      = 32;
    localparam int InstAddrBus = 32;

    localparam logic [RegBus-1:0] NOP_INST = 32'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } rom_state_e;

    // A fetch is illegal when it is not word aligned or lies beyond the array depth.
    function automatic logic addr_bad(input logic [InstAddrBus-1:0] addr, input int addr_w);
        return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != '0);
    endfunction

endpackage

// File: rtl/inst_rom_resp_if.sv
// Fetch, response and loader signals between the core/loader and the ROM responder.
interface inst_rom_resp_if
    import inst_rom_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) ();

    logic                   ce_i;
    logic [InstAddrBus-1:0] addr_i;
    logic [RegBus-1:0]      inst_o;
    logic                   inst_valid_o;
    logic                   stallreq_o;
    logic                   addr_err_o;
    logic                   ld_we_i;
    logic [ADDR_W-1:0]      ld_addr_i;
    logic [RegBus-1:0]      ld_data_i;

    modport master (
        output ce_i, addr_i, ld_we_i, ld_addr_i, ld_data_i,
        input  inst_o, inst_valid_o, stallreq_o, addr_err_o
    );

    modport slave (
        input  ce_i, addr_i, ld_we_i, ld_addr_i, ld_data_i,
        output inst_o, inst_valid_o, stallreq_o, addr_err_o
    );

endinterface

// File: rtl/inst_mem_array.sv
// Instruction storage: one write port and one registered read port. Contents are
// never reset; a same-edge write to the word being read is forwarded to the output.
module inst_mem_array
    import inst_rom_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [RegBus-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [RegBus-1:0] rdata
);

    logic [RegBus-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction fetch responder: models array wait states with an IDLE/ACCESS/HOLD FSM,
// stalls the pipeline while a word is being fetched and flags illegal fetch addresses.
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    inst_rom_resp_if.slave bus
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    rom_state_e             state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [InstAddrBus-1:0] srv_addr, srv_addr_n;
    logic                   hold_vld, hold_vld_n;
    logic                   err_q, err_n;
    logic                   start;
    logic                   rd_en;
    logic [RegBus-1:0]      rd_data;
    logic [ADDR_W-1:0]      srv_word;
    logic                   addr_new;
    logic                   addr_is_bad;
    logic                   ld_hit;

    assign srv_word    = srv_addr[ADDR_W+1:2];
    assign addr_new    = (bus.addr_i != srv_addr);
    assign addr_is_bad = addr_bad(bus.addr_i, ADDR_W);
    assign ld_hit      = bus.ld_we_i && (bus.ld_addr_i == srv_word);

    inst_mem_array #(
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (bus.ld_we_i),
        .waddr (bus.ld_addr_i),
        .wdata (bus.ld_data_i),
        .re    (rd_en),
        .raddr (srv_word),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            srv_addr <= '0;
            hold_vld <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            srv_addr <= srv_addr_n;
            hold_vld <= hold_vld_n;
            err_q    <= err_n;
        end
    end

    // The stall drops in the last ACCESS cycle (counter at 0), so a fetch stalls
    // exactly WAIT_CYCLES cycles and the word appears one edge later.
    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        srv_addr_n       = srv_addr;
        hold_vld_n       = hold_vld;
        err_n            = err_q;
        start            = 1'b0;
        rd_en            = 1'b0;
        bus.inst_o       = NOP_INST;
        bus.inst_valid_o = 1'b0;
        bus.stallreq_o   = 1'b0;
        bus.addr_err_o   = 1'b0;

        if (!bus.ce_i) begin
            state_n    = IDLE;
            hold_vld_n = 1'b0;
            err_n      = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    start = 1'b1;
                end
                HOLD: begin
                    if (addr_new || !hold_vld) begin
                        start = 1'b1;
                    end else begin
                        bus.inst_valid_o = 1'b1;
                        bus.addr_err_o   = err_q;
                        bus.inst_o       = err_q ? NOP_INST : rd_data;
                        if (ld_hit) begin
                            hold_vld_n = 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (addr_new) begin
                        start = 1'b1;
                    end else if (cnt != '0) begin
                        bus.stallreq_o = 1'b1;
                        cnt_n          = ld_hit ? CNT_LOAD : cnt - CNT_W'(1);
                    end else begin
                        rd_en      = 1'b1;
                        state_n    = HOLD;
                        hold_vld_n = 1'b1;
                        err_n      = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (start) begin
                srv_addr_n = bus.addr_i;
                if (addr_is_bad) begin
                    state_n    = HOLD;
                    hold_vld_n = 1'b1;
                    err_n      = 1'b1;
                end else begin
                    state_n        = ACCESS;
                    cnt_n          = CNT_LOAD;
                    hold_vld_n     = 1'b0;
                    err_n          = 1'b0;
                    bus.stallreq_o = 1'b1;
                end
            end
        end

        // Outputs go quiet the moment reset asserts, not at the next edge.
        if (rst) begin
            bus.inst_o       = NOP_INST;
            bus.inst_valid_o = 1'b0;
            bus.stallreq_o   = 1'b0;
            bus.addr_err_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed self-checking bench for inst_rom_resp with ADDR_W=10 and WAIT_CYCLES=2.
module tb_inst_rom_resp;

    localparam int ADDR_W = 10;
    localparam int WAIT   = 2;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    inst_rom_resp_if #(.ADDR_W(ADDR_W)) bus ();

    inst_rom_resp #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs until inst_valid_o rises, counting stall cycles and clock edges on the way.
    task automatic wait_valid(output int stalls, output int edges);
        stalls = 0;
        edges  = 0;
        while (!bus.inst_valid_o && edges < 20) begin
            if (bus.stallreq_o) stalls++;
            tick();
            edges++;
        end
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus.ld_we_i   = 1'b1;
        bus.ld_addr_i = a;
        bus.ld_data_i = d;
        tick();
        bus.ld_we_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.ce_i      = 1'b0;
        bus.addr_i    = '0;
        bus.ld_we_i   = 1'b0;
        bus.ld_addr_i = '0;
        bus.ld_data_i = '0;
        #3;
        total++;
        if ({bus.inst_o, bus.inst_valid_o, bus.stallreq_o, bus.addr_err_o} !== 35'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got inst=%h v=%b s=%b e=%b expected all zero",
                     bus.inst_o, bus.inst_valid_o, bus.stallreq_o, bus.addr_err_o);
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if ({bus.inst_valid_o, bus.stallreq_o, bus.addr_err_o} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL idle_ce0: got v=%b s=%b e=%b expected 000",
                     bus.inst_valid_o, bus.stallreq_o, bus.addr_err_o);
        end
    endtask

    task automatic test_fetch();
        load_word(10'd0, 32'h11111111);
        load_word(10'd1, 32'h22222222);
        load_word(10'd2, 32'h33333333);
        load_word(10'd3, 32'h34011100);
        bus.ce_i   = 1'b1;
        bus.addr_i = 32'h0000000C;
        #1;
        total++;
        if (bus.stallreq_o !== 1'b1 || bus.inst_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fetch_cycle0: got s=%b v=%b expected s=1 v=0", bus.stallreq_o, bus.inst_valid_o);
        end
        tick();
        total++;
        if (bus.stallreq_o !== 1'b1 || bus.inst_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fetch_cycle1: got s=%b v=%b expected s=1 v=0", bus.stallreq_o, bus.inst_valid_o);
        end
        tick();
        total++;
        if (bus.stallreq_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fetch_cycle2: got s=%b v=%b expected s=0 v=0", bus.stallreq_o, bus.inst_valid_o);
        end
        tick();
        total++;
        if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h34011100) begin
            bad++;
            $display("[TB] FAIL fetch_word: got v=%b inst=%h expected v=1 inst=34011100", bus.inst_valid_o, bus.inst_o);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus.stallreq_o !== 1'b0 || bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h34011100) begin
                bad++;
                $display("[TB] FAIL hold_%0d: got s=%b v=%b inst=%h expected s=0 v=1 inst=34011100",
                         i, bus.stallreq_o, bus.inst_valid_o, bus.inst_o);
            end
        end
    endtask

    task automatic test_addr_err();
        bus.addr_i = 32'h0000000D;
        #1;
        total++;
        if (bus.stallreq_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL misaligned_nostall: got s=%b expected 0", bus.stallreq_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.addr_err_o !== 1'b1 || bus.inst_o !== 32'h0 || bus.inst_valid_o !== 1'b1 || bus.stallreq_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL misaligned_%0d: got e=%b inst=%h v=%b s=%b expected e=1 inst=0 v=1 s=0",
                         i, bus.addr_err_o, bus.inst_o, bus.inst_valid_o, bus.stallreq_o);
            end
        end
        bus.addr_i = 32'h00001000;
        #1;
        total++;
        if (bus.stallreq_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL range_nostall: got s=%b expected 0", bus.stallreq_o);
        end
        tick();
        total++;
        if (bus.addr_err_o !== 1'b1 || bus.inst_o !== 32'h0 || bus.inst_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL out_of_range: got e=%b inst=%h v=%b expected e=1 inst=0 v=1",
                     bus.addr_err_o, bus.inst_o, bus.inst_valid_o);
        end
    endtask

    task automatic test_invalidate();
        int stalls, edges;
        bus.addr_i = 32'h0000000C;
        #1;
        wait_valid(stalls, edges);
        total++;
        if (bus.inst_o !== 32'h34011100 || bus.addr_err_o !== 1'b0 || edges != 3) begin
            bad++;
            $display("[TB] FAIL refetch_0c: got inst=%h e=%b edges=%0d expected inst=34011100 e=0 edges=3",
                     bus.inst_o, bus.addr_err_o, edges);
        end
        bus.ld_we_i   = 1'b1;
        bus.ld_addr_i = 10'd3;
        bus.ld_data_i = 32'hDEADBEEF;
        tick();
        bus.ld_we_i = 1'b0;
        #1;
        total++;
        if (bus.inst_valid_o !== 1'b0 || bus.stallreq_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL invalidate: got v=%b s=%b expected v=0 s=1", bus.inst_valid_o, bus.stallreq_o);
        end
        wait_valid(stalls, edges);
        total++;
        if (bus.inst_o !== 32'hDEADBEEF || stalls != WAIT || edges != WAIT + 1) begin
            bad++;
            $display("[TB] FAIL invalidate_refetch: got inst=%h stalls=%0d edges=%0d expected inst=deadbeef stalls=2 edges=3",
                     bus.inst_o, stalls, edges);
        end
    endtask

    task automatic test_reset_mid();
        int stalls, edges;
        bus.addr_i = 32'h00000008;
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++;
        if ({bus.inst_o, bus.inst_valid_o, bus.stallreq_o, bus.addr_err_o} !== 35'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid: got inst=%h v=%b s=%b e=%b expected all zero",
                     bus.inst_o, bus.inst_valid_o, bus.stallreq_o, bus.addr_err_o);
        end
        tick();
        rst = 1'b0;
        #1;
        wait_valid(stalls, edges);
        total++;
        if (bus.inst_o !== 32'h33333333 || stalls != WAIT || edges != WAIT + 1) begin
            bad++;
            $display("[TB] FAIL reset_refetch: got inst=%h stalls=%0d edges=%0d expected inst=33333333 stalls=2 edges=3",
                     bus.inst_o, stalls, edges);
        end
    endtask

    task automatic test_back_to_back();
        int stalls, edges;
        logic [31:0] addrs [3];
        logic [31:0] words [3];
        addrs = '{32'h0, 32'h4, 32'h8};
        words = '{32'h11111111, 32'h22222222, 32'h33333333};
        bus.ce_i = 1'b0;
        tick();
        total++;
        if ({bus.inst_o, bus.inst_valid_o, bus.stallreq_o, bus.addr_err_o} !== 35'h0) begin
            bad++;
            $display("[TB] FAIL ce_off: got inst=%h v=%b s=%b e=%b expected all zero",
                     bus.inst_o, bus.inst_valid_o, bus.stallreq_o, bus.addr_err_o);
        end
        bus.ce_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.addr_i = addrs[i];
            #1;
            wait_valid(stalls, edges);
            total++;
            if (bus.inst_o !== words[i] || stalls != WAIT || edges != WAIT + 1 || bus.stallreq_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL seq_%0d: got inst=%h stalls=%0d edges=%0d expected inst=%h stalls=2 edges=3",
                         i, bus.inst_o, stalls, edges, words[i]);
            end
        end
    endtask

    task automatic test_load_race();
        int stalls, edges;
        bus.addr_i = 32'h00000004;
        tick();
        bus.ld_we_i   = 1'b1;
        bus.ld_addr_i = 10'd1;
        bus.ld_data_i = 32'hAAAA0001;
        tick();
        bus.ld_we_i = 1'b0;
        #1;
        wait_valid(stalls, edges);
        total++;
        if (bus.inst_o !== 32'hAAAA0001 || edges != 2 || stalls != 1) begin
            bad++;
            $display("[TB] FAIL access_write_restart: got inst=%h stalls=%0d edges=%0d expected inst=aaaa0001 stalls=1 edges=2",
                     bus.inst_o, stalls, edges);
        end
        bus.addr_i = 32'h00000000;
        tick();
        tick();
        bus.ld_we_i   = 1'b1;
        bus.ld_addr_i = 10'd0;
        bus.ld_data_i = 32'hBBBB0002;
        tick();
        bus.ld_we_i = 1'b0;
        #1;
        total++;
        if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'hBBBB0002) begin
            bad++;
            $display("[TB] FAIL capture_bypass: got v=%b inst=%h expected v=1 inst=bbbb0002",
                     bus.inst_valid_o, bus.inst_o);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fetch();
        test_hold();
        test_addr_err();
        test_invalidate();
        test_reset_mid();
        test_back_to_back();
        test_load_race();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
